// File: rtl/clock_step_ctrl.sv
// clock_step_ctrl: generates the CPU clock from qzt_clk, either free-running
// (RUN, period set by `period`) or as single manually stepped pulses.
//
// Ports:
//   qzt_clk     in   sole clock, rising edge
//   reset       in   synchronous, active-low
//   run_toggle  in   one-cycle pulse, toggles RUN/HALT
//   step_req    in   one-cycle pulse, requests one cpu_clk cycle from HALT
//   halt_req    in   level from CPU, forces a stop and blocks starting
//   period      in   [28:0] run-mode cpu_clk period in qzt_clk cycles
//   cpu_clk     out  clock level to CPU/RAM, straight from a flop
//   clk_tick    out  one-cycle pulse on each cpu_clk rising edge
//   running     out  high while in RUN
//   step_count  out  [15:0] cpu_clk rising edges issued (wraps)
//
// Build option: define CLOCK_STEP_COUNTER_EN to build the step_count
// register; otherwise step_count is tied to zero.
module clock_step_ctrl #(
  parameter int unsigned STEP_WIDTH = 4,
  parameter int unsigned PERIOD_MIN = 2
) (
  input  logic        qzt_clk,
  input  logic        reset,
  input  logic        run_toggle,
  input  logic        step_req,
  input  logic        halt_req,
  input  logic [28:0] period,
  output logic        cpu_clk,
  output logic        clk_tick,
  output logic        running,
  output logic [15:0] step_count
);

  localparam int unsigned PERIOD_W  = 29;
  localparam int unsigned PERIOD_W1 = PERIOD_W + 1;
  localparam int unsigned CNT_W     = 29;
  localparam int unsigned COUNT_W   = 16;
  // A period below 2 would leave an empty low phase, so never go under 2.
  localparam int unsigned PMIN_EFF  = (PERIOD_MIN < 2) ? 2 : PERIOD_MIN;

  typedef enum logic [1:0] {
    HALT    = 2'd0,
    RUN     = 2'd1,
    STEP_HI = 2'd2,
    STEP_LO = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 stop_q, stop_d;
  logic                 cpu_clk_d, tick_d;
  logic                 cnt_zero, stop_now;

  logic [PERIOD_W-1:0]  p_eff;
  logic [PERIOD_W1-1:0] hi_len;
  logic [CNT_W-1:0]     hi_m1, lo_m1, step_m1;

  // Phase lengths, stored as remaining-cycles-minus-one; sampled only at
  // phase boundaries so a period change never alters a phase in flight.
  assign p_eff   = (period < PERIOD_W'(PMIN_EFF)) ? PERIOD_W'(PMIN_EFF) : period;
  assign hi_len  = (PERIOD_W1'(p_eff) + PERIOD_W1'(1)) >> 1;
  assign hi_m1   = CNT_W'(hi_len - PERIOD_W1'(1));
  assign lo_m1   = CNT_W'((p_eff >> 1) - PERIOD_W'(1));
  assign step_m1 = CNT_W'(STEP_WIDTH - 1);

  assign cnt_zero = (cnt_q == '0);
  assign stop_now = stop_q | run_toggle | halt_req;

  // State and output registers.
  always_ff @(posedge qzt_clk) begin
    if (!reset) begin
      state_q  <= HALT;
      cnt_q    <= '0;
      stop_q   <= 1'b0;
      cpu_clk  <= 1'b0;
      clk_tick <= 1'b0;
      running  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stop_q   <= stop_d;
      cpu_clk  <= cpu_clk_d;
      clk_tick <= tick_d;
      running  <= (state_d == RUN);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stop_d    = stop_q;
    cpu_clk_d = cpu_clk;
    tick_d    = 1'b0;

    case (state_q)
      HALT: begin
        stop_d = 1'b0;
        if (!halt_req) begin
          // run_toggle has priority over step_req
          if (run_toggle) begin
            state_d   = RUN;
            cpu_clk_d = 1'b1;
            tick_d    = 1'b1;
            cnt_d     = hi_m1;
          end else if (step_req) begin
            state_d   = STEP_HI;
            cpu_clk_d = 1'b1;
            tick_d    = 1'b1;
            cnt_d     = step_m1;
          end
        end
      end

      STEP_HI: begin
        if (cnt_zero) begin
          state_d   = STEP_LO;
          cpu_clk_d = 1'b0;
          cnt_d     = step_m1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      STEP_LO: begin
        if (cnt_zero) state_d = HALT;
        else          cnt_d   = cnt_q - CNT_W'(1);
      end

      RUN: begin
        if (run_toggle || halt_req) stop_d = 1'b1;
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (cpu_clk) begin
          cpu_clk_d = 1'b0;
          cnt_d     = lo_m1;
        end else if (stop_now) begin
          // a stop only lands at the end of a low phase
          state_d = HALT;
          stop_d  = 1'b0;
        end else begin
          cpu_clk_d = 1'b1;
          tick_d    = 1'b1;
          cnt_d     = hi_m1;
        end
      end

      default: state_d = HALT;
    endcase
  end

`ifdef CLOCK_STEP_COUNTER_EN
  // Rising-edge counter, updated together with clk_tick.
  always_ff @(posedge qzt_clk) begin
    if (!reset) step_count <= '0;
    else if (tick_d) step_count <= step_count + COUNT_W'(1);
  end
`else
  assign step_count = '0;
`endif

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Directed self-checking bench for clock_step_ctrl.
module tb_clock_step_ctrl;

  logic        qzt_clk = 1'b0;
  logic        reset;
  logic        run_toggle;
  logic        step_req;
  logic        halt_req;
  logic [28:0] period;
  logic        cpu_clk;
  logic        clk_tick;
  logic        running;
  logic [15:0] step_count;

  int ntests = 0;
  int nfail  = 0;

`ifdef CLOCK_STEP_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  clock_step_ctrl #(.STEP_WIDTH(4), .PERIOD_MIN(2)) dut (
    .qzt_clk    (qzt_clk),
    .reset      (reset),
    .run_toggle (run_toggle),
    .step_req   (step_req),
    .halt_req   (halt_req),
    .period     (period),
    .cpu_clk    (cpu_clk),
    .clk_tick   (clk_tick),
    .running    (running),
    .step_count (step_count)
  );

  always #5 qzt_clk = ~qzt_clk;

  function automatic logic [31:0] exp_cnt(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntests++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // advance one qzt_clk cycle; outputs are then sampled 1 ns after the edge
  task automatic step();
    @(posedge qzt_clk);
    #1;
  endtask

  // check n consecutive cycles of cpu_clk at lvl; tick only on the first if asked
  task automatic expect_phase(input string tag, input logic lvl, input int n, input logic tick_first);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_clk"},  32'(cpu_clk),  32'(lvl));
      chk({tag, "_tick"}, 32'(clk_tick), 32'((i == 0) && tick_first));
      step();
    end
  endtask

  initial begin
    reset = 1'b0; run_toggle = 1'b0; step_req = 1'b0; halt_req = 1'b0;
    period = 29'd10;
    step(); step();
    // reset state
    chk("rst_clk",     32'(cpu_clk),    32'd0);
    chk("rst_tick",    32'(clk_tick),   32'd0);
    chk("rst_running", 32'(running),    32'd0);
    chk("rst_count",   32'(step_count), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) step();

    // Test 1: single step, 4 high / 4 low, then idle in HALT
    step_req = 1'b1; step(); step_req = 1'b0;
    expect_phase("t1_hi", 1'b1, 4, 1'b1);
    expect_phase("t1_lo", 1'b0, 4, 1'b0);
    chk("t1_count", 32'(step_count), exp_cnt(1));
    chk("t1_running", 32'(running), 32'd0);
    expect_phase("t1_halt", 1'b0, 3, 1'b0);

    // Test 2: run at period 10 from a fresh reset
    reset = 1'b0; step(); reset = 1'b1;
    period = 29'd10;
    run_toggle = 1'b1; step(); run_toggle = 1'b0;
    chk("t2_running", 32'(running), 32'd1);
    for (int p = 0; p < 9; p++) begin
      expect_phase("t2_hi", 1'b1, 5, 1'b1);
      expect_phase("t2_lo", 1'b0, 5, 1'b0);
    end
    expect_phase("t2_hi", 1'b1, 5, 1'b1);
    expect_phase("t2_lo", 1'b0, 4, 1'b0);
    chk("t2_count", 32'(step_count), exp_cnt(10));
    chk("t2_running2", 32'(running), 32'd1);

    // Test 3: period 7 -> 4/3, then period 0 -> 1/1
    period = 29'd7;
    expect_phase("t2_lolast", 1'b0, 1, 1'b0);
    expect_phase("t3_hi7", 1'b1, 4, 1'b1);
    expect_phase("t3_lo7", 1'b0, 3, 1'b0);
    expect_phase("t3_hi7b", 1'b1, 4, 1'b1);
    expect_phase("t3_lo7b", 1'b0, 2, 1'b0);
    period = 29'd0;
    expect_phase("t3_lo7c", 1'b0, 1, 1'b0);
    for (int p = 0; p < 3; p++) begin
      expect_phase("t3_hi0", 1'b1, 1, 1'b1);
      expect_phase("t3_lo0", 1'b0, 1, 1'b0);
    end

    // Test 4: halt_req in 2nd high cycle finishes high + low, then HALT
    reset = 1'b0; step(); reset = 1'b1;
    chk("t4_rst_clk", 32'(cpu_clk), 32'd0);
    period = 29'd10;
    run_toggle = 1'b1; step(); run_toggle = 1'b0;
    chk("t4_running", 32'(running), 32'd1);
    expect_phase("t4_hi1", 1'b1, 1, 1'b1);
    halt_req = 1'b1;
    expect_phase("t4_hi", 1'b1, 4, 1'b0);
    chk("t4_running_drain", 32'(running), 32'd1);
    expect_phase("t4_lo", 1'b0, 5, 1'b0);
    chk("t4_running_off", 32'(running), 32'd0);
    step_req = 1'b1; step(); step_req = 1'b0;
    expect_phase("t4_blocked", 1'b0, 4, 1'b0);
    halt_req = 1'b0;
    expect_phase("t4_noqueue", 1'b0, 3, 1'b0);
    chk("t4_count", 32'(step_count), exp_cnt(1));

    // Test 5: run_toggle beats step_req; then stop via run_toggle
    run_toggle = 1'b1; step_req = 1'b1; step(); run_toggle = 1'b0; step_req = 1'b0;
    chk("t5_running", 32'(running), 32'd1);
    run_toggle = 1'b1;
    expect_phase("t5_hi1", 1'b1, 1, 1'b1);
    run_toggle = 1'b0;
    expect_phase("t5_hi", 1'b1, 4, 1'b0);
    expect_phase("t5_lo", 1'b0, 5, 1'b0);
    chk("t5_running_off", 32'(running), 32'd0);
    expect_phase("t5_halt", 1'b0, 2, 1'b0);
    // step_req inside STEP_HI and run_toggle inside STEP_LO are dropped
    step_req = 1'b1; step(); step_req = 1'b0;
    expect_phase("t5_s_hi1", 1'b1, 1, 1'b1);
    step_req = 1'b1;
    expect_phase("t5_s_hi2", 1'b1, 1, 1'b0);
    step_req = 1'b0;
    expect_phase("t5_s_hi", 1'b1, 2, 1'b0);
    expect_phase("t5_s_lo1", 1'b0, 1, 1'b0);
    run_toggle = 1'b1;
    expect_phase("t5_s_lo2", 1'b0, 1, 1'b0);
    run_toggle = 1'b0;
    expect_phase("t5_s_lo", 1'b0, 2, 1'b0);
    chk("t5_s_running", 32'(running), 32'd0);
    expect_phase("t5_s_halt", 1'b0, 4, 1'b0);
    chk("t5_count", 32'(step_count), exp_cnt(3));

    // Test 6: reset in the middle of STEP_HI
    step_req = 1'b1; step(); step_req = 1'b0;
    expect_phase("t6_hi", 1'b1, 2, 1'b1);
    reset = 1'b0; step();
    chk("t6_clk",   32'(cpu_clk),    32'd0);
    chk("t6_count", 32'(step_count), 32'd0);
    chk("t6_tick",  32'(clk_tick),   32'd0);
    run_toggle = 1'b1; step_req = 1'b1; step();
    chk("t6_inreset_clk", 32'(cpu_clk), 32'd0);
    chk("t6_inreset_run", 32'(running), 32'd0);
    run_toggle = 1'b0; step_req = 1'b0; reset = 1'b1;
    expect_phase("t6_after", 1'b0, 4, 1'b0);
    chk("t6_running", 32'(running), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/clock_step_ctrl.md
CLOCK_STEP_CTRL -- requirements
Module: clock_step_ctrl

Interface
REQ-001 The module SHALL have parameter STEP_WIDTH, default 4, giving the qzt_clk cycles per phase (high and low) of a single-step pulse.
REQ-002 The module SHALL have parameter PERIOD_MIN, default 2, giving the smallest run period accepted, in qzt_clk cycles.
REQ-003 The module SHALL have port qzt_clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-005 The module SHALL have port run_toggle, input, 1 bit: debounced one-cycle pulse that toggles between RUN and HALT.
REQ-006 The module SHALL have port step_req, input, 1 bit: debounced one-cycle pulse requesting one CPU clock cycle.
REQ-007 The module SHALL have port halt_req, input, 1 bit: level from the CPU (HLT executed) that forces a stop.
REQ-008 The module SHALL have port period, input, 29 bits: run-mode cpu_clk period in qzt_clk cycles.
REQ-009 The module SHALL have port cpu_clk, output, 1 bit: clock level driving the CPU and RAM clk_in.
REQ-010 The module SHALL have port clk_tick, output, 1 bit: one-cycle pulse coincident with each cpu_clk rising edge.
REQ-011 The module SHALL have port running, output, 1 bit: high while in state RUN.
REQ-012 The module SHALL have port step_count, output, 16 bits: count of cpu_clk rising edges issued.

Function
REQ-013 The FSM SHALL have states HALT, RUN, STEP_HI and STEP_LO, all registered.
REQ-014 In HALT, when run_toggle=1 and halt_req=0, the FSM SHALL go to RUN, with cpu_clk rising on the next cycle.
REQ-015 In HALT, when step_req=1, run_toggle=0 and halt_req=0, the FSM SHALL go to STEP_HI.
REQ-016 When run_toggle and step_req assert in the same cycle in HALT, run_toggle SHALL win.
REQ-017 STEP_HI SHALL hold cpu_clk=1 for exactly STEP_WIDTH cycles, then STEP_LO SHALL hold cpu_clk=0 for exactly STEP_WIDTH cycles, then the FSM SHALL return to HALT.
REQ-018 step_req and run_toggle SHALL be ignored and not queued in STEP_HI and STEP_LO.
REQ-019 In RUN, cpu_clk SHALL be high for ceil(P/2) cycles and low for floor(P/2) cycles, where P = max(period, PERIOD_MIN).
REQ-020 A change of period in RUN SHALL take effect at the next cpu_clk phase boundary.
REQ-021 In RUN, step_req SHALL be ignored.
REQ-022 In RUN, run_toggle or halt_req=1 SHALL request a stop; the FSM SHALL finish the current high phase and its following low phase, then enter HALT.
REQ-023 A stop SHALL never truncate a phase and SHALL never cause a glitch on cpu_clk.
REQ-024 halt_req=1 SHALL block entry to RUN and STEP_HI from HALT.
REQ-025 clk_tick SHALL be 1 in exactly the cycle where cpu_clk goes from 0 to 1, and 0 otherwise.
REQ-026 step_count SHALL increment by 1 on each clk_tick and SHALL wrap from 16'hFFFF to 0.
REQ-027 cpu_clk SHALL be driven directly from a flip-flop.

Reset
REQ-028 When reset=0 at a qzt_clk edge, the FSM SHALL enter HALT, regardless of the current state, including mid-phase.
REQ-029 The same reset SHALL clear cpu_clk, clk_tick, running, step_count, the phase counter and any pending stop.
REQ-030 While reset=0, run_toggle, step_req and halt_req SHALL be ignored.

Configuration
REQ-031 With macro CLOCK_STEP_COUNTER_EN defined, step_count SHALL behave per REQ-026.
REQ-032 Without CLOCK_STEP_COUNTER_EN, step_count SHALL be a constant 0 and no counter register SHALL be built.

Verification
REQ-033 Test 1: reset, then step_req pulse at cycle 10 -> cpu_clk high cycles 11-14 and low 15-18; clk_tick=1 at 11 only; step_count=1; state back to HALT.
REQ-034 Test 2: period=10, run_toggle pulse -> cpu_clk 5 high / 5 low repeating; running=1; after 100 cycles, step_count=10.
REQ-035 Test 3: period=7 in RUN -> 4 high / 3 low; period=0 -> 1 high / 1 low.
REQ-036 Test 4: RUN, period=10, halt_req raised in the 2nd cycle of a high phase -> the high phase completes (5 cycles), 5 low cycles follow, then HALT, running=0; a later step_req is ignored while halt_req=1.
REQ-037 Test 5: run_toggle and step_req asserted together in HALT -> RUN entered, no single step issued; step_req during STEP_HI -> exactly one pulse total.
REQ-038 Test 6: reset=0 in the middle of STEP_HI -> cpu_clk=0 and step_count=0 the next cycle; with the macro undefined, step_count stays 0 throughout Test 2.
